// File: rtl/avm_pio_pkg.sv
// Shared definitions for the Avalon-MM PIO read master: sweep FSM states
// and the largest supported fixed slave read latency.
package avm_pio_pkg;

  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/avm_rd_lat_pipe.sv
// Read-latency tag pipe: carries a valid bit and the word address of each
// accepted read through DEPTH stages, so the tag emerges on the exact cycle
// the fixed-latency slave presents its data.
module avm_rd_lat_pipe #(
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_tag,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_tag,
  output logic              empty
);

  logic [DEPTH-1:0]  vld_p;
  logic [ADDR_W-1:0] tag_p [DEPTH];

  // Shift valid and tag one stage per cycle; reset flushes any reads in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) tag_p[i] <= '0;
    end else begin
      vld_p[0] <= in_valid;
      tag_p[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign out_valid = vld_p[DEPTH-1];
  assign out_tag   = tag_p[DEPTH-1];
  assign empty     = ~|vld_p;

endmodule

// File: rtl/avm_pio_read_master.sv
// Avalon-MM PIO read master: on a start pulse, reads NUM_WORDS consecutive
// words from address 0 of a fixed-latency slave (honouring waitrequest) and
// reports each word as a one-cycle result pulse, then pulses done.
// Optional feature macro: AVM_PIO_READ_MASTER_CHANGE_DETECT_EN adds a shadow
// copy of the last sweep and a 'changed' flag alongside each result.
module avm_pio_read_master
  import avm_pio_pkg::*;
#(
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              result_valid,
  output logic [ADDR_W-1:0] result_index,
  output logic [DATA_W-1:0] result_data
`ifdef AVM_PIO_READ_MASTER_CHANGE_DETECT_EN
  ,
  output logic              changed
`endif
);

  // Latency clamped into the supported range so the pipe is never sized 0.
  localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                       ((RD_LAT < 1) ? 1 : RD_LAT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t            state;
  logic              accept;
  logic              smp_vld;
  logic [ADDR_W-1:0] smp_tag;
  logic              pipe_empty;

  assign accept = avm_read & ~avm_waitrequest;

  avm_rd_lat_pipe #(
    .ADDR_W (ADDR_W),
    .DEPTH  (LAT)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_tag    (avm_address),
    .out_valid (smp_vld),
    .out_tag   (smp_tag),
    .empty     (pipe_empty)
  );

  // Sweep sequencer: issues reads, waits for the pipe to drain, pulses done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      avm_address <= '0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= REQ;
            avm_address <= '0;
            avm_read    <= 1'b1;
            busy        <= 1'b1;
          end
        end
        REQ: begin
          if (accept) begin
            if (avm_address == LAST_ADDR) begin
              state    <= DRAIN;
              avm_read <= 1'b0;
            end else begin
              avm_address <= avm_address + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The pipe holds the last word on entry; once it empties, that
          // word is on the result outputs this very cycle.
          if (pipe_empty) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state       <= IDLE;
          avm_address <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result stage: register the slave word on the cycle its tag leaves the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid <= 1'b0;
      result_index <= '0;
      result_data  <= '0;
    end else begin
      result_valid <= smp_vld;
      if (smp_vld) begin
        result_index <= smp_tag;
        result_data  <= avm_readdata;
      end
    end
  end

`ifdef AVM_PIO_READ_MASTER_CHANGE_DETECT_EN
  logic [DATA_W-1:0] shadow [NUM_WORDS];

  // Change detect: compare each sampled word with the previous sweep's copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      changed <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) shadow[i] <= '0;
    end else begin
      changed <= smp_vld && (avm_readdata != shadow[smp_tag]);
      if (smp_vld) shadow[smp_tag] <= avm_readdata;
    end
  end
`endif

endmodule

// File: tb/tb_avm_pio_read_master.sv
// Bench for avm_pio_read_master: two instances (read latency 1 and 3) share
// stimulus; each has a fixed-latency slave model, and a sweep-level reference
// model predicts reads, results, busy and done cycle by cycle.
module tb_avm_pio_read_master;

  localparam int AW = 2;
  localparam int DW = 32;
  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, waitreq = 1'b0;
  logic          o_busy [2], o_done [2], o_read [2], o_rv [2];
  logic [AW-1:0] o_addr [2], o_ridx [2];
  logic [DW-1:0] o_rdat [2], rdata [2];
`ifdef AVM_PIO_READ_MASTER_CHANGE_DETECT_EN
  logic          o_chg  [2];
`endif
  logic [DW-1:0] mem [NW];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [3:0]    ah = '0;
    logic [AW-1:0] aa [4];
    // Slave: data valid exactly L cycles after acceptance, junk otherwise.
    always @(posedge clk) begin
      ah    <= {ah[2:0], o_read[g] & ~waitreq};
      aa[0] <= o_addr[g];
      for (int k = 1; k < 4; k++) aa[k] <= aa[k-1];
    end
    assign rdata[g] = ah[L-1] ? mem[aa[L-1]] : 32'hDEAD_BEEF;

    avm_pio_read_master #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .RD_LAT(L)
    ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .busy            (o_busy[g]),
      .done            (o_done[g]),
      .avm_address     (o_addr[g]),
      .avm_read        (o_read[g]),
      .avm_waitrequest (waitreq),
      .avm_readdata    (rdata[g]),
      .result_valid    (o_rv[g]),
      .result_index    (o_ridx[g]),
      .result_data     (o_rdat[g])
`ifdef AVM_PIO_READ_MASTER_CHANGE_DETECT_EN
      ,
      .changed         (o_chg[g])
`endif
    );
  end

  typedef struct {
    logic          start;
    logic          wr;
    logic          busy;
    logic          done;
    logic          rd;
    logic [AW-1:0] addr;
    logic          rv;
    logic [AW-1:0] idx;
    logic [DW-1:0] dat;
  } vec_t;
  vec_t tbl [9];

  int vectors = 0, miscompares = 0;
  int n = 0;
  // Reference model state per instance.
  int act [2], iss [2], acc [2], rnx [2], done_at [2];
  int due [2][NW];
  logic [DW-1:0] edat [2][NW], shad [2][NW];
  bit rst_chk;
  int dcnt [2], rvcnt [2], chgcnt [2], hold2;

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(string nm, int i, logic [DW-1:0] got, logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, i, n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; iss[i] = 0; acc[i] = 0; rnx[i] = 0; done_at[i] = -1;
      for (int w = 0; w < NW; w++) shad[i][w] = '0;
    end
    rst_chk = 1'b1;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin dcnt[i] = 0; rvcnt[i] = 0; chgcnt[i] = 0; end
    hold2 = 0;
  endtask

  task automatic check_inst(int i);
    bit erv, edn;
    chk("avm_read", i, 32'(o_read[i]), 32'(iss[i] != 0));
    if (iss[i] != 0) chk("avm_address", i, 32'(o_addr[i]), 32'(acc[i]));
    if (rst_chk) begin
      chk("rst_address", i, 32'(o_addr[i]), 32'd0);
      chk("rst_result_index", i, 32'(o_ridx[i]), 32'd0);
      chk("rst_result_data", i, o_rdat[i], 32'd0);
    end
    erv = (rnx[i] < acc[i]) && (due[i][rnx[i]] == n);
    chk("result_valid", i, 32'(o_rv[i]), 32'(erv));
    if (erv) begin
      chk("result_index", i, 32'(o_ridx[i]), 32'(rnx[i]));
      chk("result_data", i, o_rdat[i], edat[i][rnx[i]]);
`ifdef AVM_PIO_READ_MASTER_CHANGE_DETECT_EN
      chk("changed", i, 32'(o_chg[i]), 32'(edat[i][rnx[i]] != shad[i][rnx[i]]));
      shad[i][rnx[i]] = edat[i][rnx[i]];
`endif
      rnx[i]++;
    end
`ifdef AVM_PIO_READ_MASTER_CHANGE_DETECT_EN
    else chk("changed_idle", i, 32'(o_chg[i]), 32'd0);
    if (o_chg[i] === 1'b1) chgcnt[i]++;
`endif
    edn = (n == done_at[i]);
    chk("done", i, 32'(o_done[i]), 32'(edn));
    chk("busy", i, 32'(o_busy[i]), 32'((act[i] != 0) && !edn));
    if (o_done[i] === 1'b1) dcnt[i]++;
    if (o_rv[i] === 1'b1) rvcnt[i]++;
    if (i == 0 && o_read[0] === 1'b1 && o_addr[0] == 2'd2) hold2++;
  endtask

  task automatic update_inst(int i);
    if (reset) return;
    if (iss[i] != 0 && !waitreq) begin
      due[i][acc[i]]  = n + lat(i) + 1;
      edat[i][acc[i]] = mem[acc[i]];
      acc[i]++;
      if (acc[i] == NW) begin
        iss[i]     = 0;
        done_at[i] = n + lat(i) + 2;
      end
    end
    if (n == done_at[i]) act[i] = 0;
    else if (start && act[i] == 0) begin
      act[i] = 1; iss[i] = 1; acc[i] = 0; rnx[i] = 0;
    end
  endtask

  task automatic sample();
    for (int i = 0; i < 2; i++) check_inst(i);
    rst_chk = 1'b0;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 0; iss[i] = 0; acc[i] = 0; rnx[i] = 0; done_at[i] = -1;
        for (int w = 0; w < NW; w++) shad[i][w] = '0;
      end
      rst_chk = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) update_inst(i);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Run until both models are idle; optional random waitrequest, extra
  // start pulses while busy, and a reset at cycle rst_at (if >= 0).
  task automatic run(int maxc, bit rnd, int rst_at);
    int c = 0;
    while ((act[0] != 0 || act[1] != 0) && c < maxc) begin
      if (rnd) begin
        waitreq = ($urandom_range(0, 3) == 0);
        start   = (act[0] != 0) && (act[1] != 0) && ($urandom_range(0, 7) == 0);
      end
      reset = (c == rst_at);
      cyc();
      c++;
    end
    start = 1'b0; waitreq = 1'b0; reset = 1'b0;
    vectors++;
    if (act[0] != 0 || act[1] != 0) begin
      miscompares++;
      $display("FAIL sweep_timeout cycle %0d: still active after %0d cycles, required idle", n, maxc);
    end
  endtask

  task automatic sweep();
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(100, 1'b0, -1);
    cyc(); cyc();
  endtask

  initial begin
    //          start wr busy done rd addr rv idx dat
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 32'h1000_0000};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 2'd1, 32'h1000_0001};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 32'h1000_0002};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 32'h1000_0003};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0};
    for (int a = 0; a < NW; a++) mem[a] = 32'h1000_0000 + 32'(a);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    clr_counts();

    // Basic sweep, latency 1, with starts while busy and in the done cycle.
    for (int k = 0; k < 9; k++) begin
      start   = tbl[k].start;
      waitreq = tbl[k].wr;
      @(negedge clk);
      chk("tbl_busy", 0, 32'(o_busy[0]), 32'(tbl[k].busy));
      chk("tbl_done", 0, 32'(o_done[0]), 32'(tbl[k].done));
      chk("tbl_read", 0, 32'(o_read[0]), 32'(tbl[k].rd));
      if (tbl[k].rd || k == 0) chk("tbl_address", 0, 32'(o_addr[0]), 32'(tbl[k].addr));
      chk("tbl_result_valid", 0, 32'(o_rv[0]), 32'(tbl[k].rv));
      if (tbl[k].rv) begin
        chk("tbl_result_index", 0, 32'(o_ridx[0]), 32'(tbl[k].idx));
        chk("tbl_result_data", 0, o_rdat[0], tbl[k].dat);
      end
      sample();
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    run(100, 1'b0, -1);
    cyc(); cyc();
    for (int i = 0; i < 2; i++) begin
      chk("basic_done_count", i, 32'(dcnt[i]), 32'd1);
      chk("basic_result_count", i, 32'(rvcnt[i]), 32'd4);
    end

    // Waitrequest held for 3 cycles while address 2 is presented.
    clr_counts();
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    waitreq = 1'b1;
    cyc(); cyc(); cyc();
    waitreq = 1'b0;
    run(100, 1'b0, -1);
    cyc(); cyc();
    chk("wait_addr2_hold_cycles", 0, 32'(hold2), 32'd4);
    for (int i = 0; i < 2; i++) begin
      chk("wait_result_count", i, 32'(rvcnt[i]), 32'd4);
      chk("wait_done_count", i, 32'(dcnt[i]), 32'd1);
    end

    // Reset two cycles after start aborts the sweep; a new sweep is clean.
    clr_counts();
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    repeat (6) cyc();
    for (int i = 0; i < 2; i++) begin
      chk("abort_done_count", i, 32'(dcnt[i]), 32'd0);
      chk("abort_result_count", i, 32'(rvcnt[i]), 32'd0);
    end
    clr_counts();
    sweep();
    for (int i = 0; i < 2; i++) begin
      chk("after_abort_done_count", i, 32'(dcnt[i]), 32'd1);
      chk("after_abort_result_count", i, 32'(rvcnt[i]), 32'd4);
    end

    // Randomized sweeps: random data, waitrequest, extra starts, one reset.
    for (int sw = 0; sw < 8; sw++) begin
      for (int a = 0; a < NW; a++) mem[a] = $urandom;
      start = 1'b1; cyc(); start = 1'b0;
      run(300, 1'b1, (sw == 5) ? int'($urandom_range(1, 6)) : -1);
      cyc(); cyc();
    end

`ifdef AVM_PIO_READ_MASTER_CHANGE_DETECT_EN
    // Two sweeps with only word 1 changing between them.
    reset = 1'b1; cyc(); reset = 1'b0;
    mem[0] = 32'd0; mem[1] = 32'd5; mem[2] = 32'd3; mem[3] = 32'd8;
    clr_counts();
    sweep();
    for (int i = 0; i < 2; i++) chk("chg_sweep1_count", i, 32'(chgcnt[i]), 32'd3);
    mem[1] = 32'd6;
    clr_counts();
    sweep();
    for (int i = 0; i < 2; i++) chk("chg_sweep2_count", i, 32'(chgcnt[i]), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avm_pio_read_master.md
AVM_PIO_READ_MASTER -- requirements
Module: avm_pio_read_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 2, Avalon word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, read data width.
REQ-003 The block SHALL have parameter NUM_WORDS, default 4, range 1..2**ADDR_W, number of consecutive words read per sweep starting at address 0.
REQ-004 The block SHALL have parameter RD_LAT, default 1, range 1..4, fixed slave read latency in cycles (no readdatavalid).
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: one-cycle request to begin a sweep.
REQ-008 Port busy, output, 1: high from sweep start until done.
REQ-009 Port done, output, 1: one-cycle pulse at sweep end.
REQ-010 Port avm_address, output, ADDR_W: word address of current read.
REQ-011 Port avm_read, output, 1: read request.
REQ-012 Port avm_waitrequest, input, 1: slave stall; tie 0 for fixed-latency PIO slaves.
REQ-013 Port avm_readdata, input, DATA_W: slave read data.
REQ-014 Port result_valid, output, 1: one-cycle pulse per captured word.
REQ-015 Port result_index, output, ADDR_W: address of captured word.
REQ-016 Port result_data, output, DATA_W: captured word.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DRAIN, DONE.
REQ-018 IDLE: start=1 -> REQ next cycle, address counter=0, busy=1; start ignored in every other state.
REQ-019 REQ: avm_read=1, avm_address=counter; read accepted on the cycle avm_read=1 and avm_waitrequest=0.
REQ-020 While avm_waitrequest=1, avm_address and avm_read SHALL hold stable.
REQ-021 On accept with counter<NUM_WORDS-1, counter increments and REQ continues, so back-to-back reads issue one per cycle with no waitrequest.
REQ-022 On accept of the last word -> DRAIN; avm_read=0 from the next cycle.
REQ-023 Each accepted read SHALL be tagged into an RD_LAT-deep shift pipe; avm_readdata is sampled exactly RD_LAT cycles after acceptance.
REQ-024 The sample cycle SHALL drive result_valid=1 with result_index=tagged address and result_data=sampled value, registered one cycle later (total accept-to-result_valid = RD_LAT+1 cycles).
REQ-025 DRAIN -> DONE when the pipe is empty and the last result has been emitted; DONE pulses done=1, busy=0 the same cycle, -> IDLE.
REQ-026 NUM_WORDS=1 SHALL issue exactly one read; the counter never wraps past NUM_WORDS-1.
REQ-027 Exactly NUM_WORDS result_valid pulses per sweep, indices ascending 0..NUM_WORDS-1.

Reset
REQ-028 With reset=1 at a clock edge: state=IDLE, counter=0, pipe cleared; busy, done, avm_read, result_valid=0; avm_address, result_index, result_data=0.
REQ-029 Reset mid-sweep SHALL abort it: avm_read=0 from the following cycle, no further result_valid, and no done pulse.

Configuration
REQ-030 Macro AVM_PIO_READ_MASTER_CHANGE_DETECT_EN, when defined, SHALL add a NUM_WORDS x DATA_W shadow array (reset to 0) and output port changed (1 bit), driven high alongside result_valid when result_data differs from the shadow entry, after which the shadow entry is updated.
REQ-031 Without the macro, the shadow array and the changed port SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package avm_pio_pkg SHALL hold the FSM state enum and the RD_LAT maximum constant (4).
REQ-033 The latency pipe SHALL be sub-module avm_rd_lat_pipe (valid + ADDR_W tag shift register, depth RD_LAT).

Verification
REQ-034 NUM_WORDS=4, RD_LAT=1, waitrequest=0, slave returns 32'h1000_0000+addr; pulse start -> reads at addresses 0,1,2,3 on 4 consecutive cycles; results 0..3 with data 1000_0000..1000_0003; done 1 cycle after last result_valid.
REQ-035 waitrequest=1 for 3 cycles on address 2 -> address 2 held for 4 cycles with avm_read=1; exactly 4 results, in order.
REQ-036 RD_LAT=3 -> each result_valid occurs 4 cycles after its accept; no overlap or lost words.
REQ-037 start re-asserted while busy=1 -> ignored; exactly one done per sweep.
REQ-038 reset asserted 2 cycles after start -> avm_read=0 the next cycle; no done; new start afterwards gives a full clean sweep.
REQ-039 With CHANGE_DETECT_EN: two sweeps with only word 1 changed (5->6) -> changed=1 for all non-zero words in sweep 1; in sweep 2 only index 1.
